// File: rtl/main_mem_responder.sv
// ============================================================================
// main_mem_responder
// ----------------------------------------------------------------------------
// Main-memory side of the cache-to-memory (cm_) interface. It answers cache
// line-fill reads from a word-organised backing RAM after a programmable
// latency. It absorbs fire-and-forget write-backs through a small posted-write
// FIFO that drains one entry into the RAM per cycle.
//
// Parameters
//   ADDR_WIDTH   : word-address bits; the RAM holds 2**ADDR_WIDTH 32-bit words.
//                  Word index = cm_*Addr[ADDR_WIDTH+1:2]. Supported range 1..29.
//   READ_LATENCY : cycles from an accepted read request to cm_ReadReady (1..15).
//   WBUF_DEPTH   : posted-write buffer entries (power of two, >= 2).
//
// Ports
//   CLK            in   clock, all state on the rising edge
//   Reset          in   asynchronous, active-high reset
//   cm_ReadValid   in   one-cycle read request pulse (ignored unless idle)
//   cm_ReadAddr    in   byte address of the read
//   cm_WriteValid  in   one-cycle write pulse (no back-pressure)
//   cm_WriteAddr   in   byte address of the write
//   cm_WriteData   in   write data
//   cm_ReadReady   out  one-cycle response pulse; cm_ReadData valid with it
//   cm_ReadData    out  read data; holds the last returned value
//   mem_Busy       out  high while a read is outstanding
//   wbuf_Overflow  out  sticky; a write was dropped on a full buffer
//
// Build option
//   MEM_RAW_BYPASS_EN : when defined, a read that hits a still-buffered write
//   takes the newest matching buffer entry (forwarding), so latency is always
//   exactly READ_LATENCY. When undefined, such a read waits in STALL until
//   every matching entry has drained to the RAM.
// ============================================================================
module main_mem_responder #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 4,
    parameter int WBUF_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        cm_ReadValid,
    input  logic [31:0] cm_ReadAddr,
    input  logic        cm_WriteValid,
    input  logic [31:0] cm_WriteAddr,
    input  logic [31:0] cm_WriteData,
    output logic        cm_ReadReady,
    output logic [31:0] cm_ReadData,
    output logic        mem_Busy,
    output logic        wbuf_Overflow
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int MEM_WORDS = 1 << ADDR_WIDTH;
    localparam int PTR_W     = $clog2(WBUF_DEPTH);
    // One extra count bit tells a full buffer from an empty one when the
    // read and write pointers are equal.
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [CNT_W-1:0] WBUF_FULL_CNT = CNT_W'(WBUF_DEPTH);
    localparam logic [3:0]       LAT_LOAD      = 4'(READ_LATENCY - 1);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // ------------------------------------------------------------------------
    // Address decode: byte offset and bits above the RAM size are ignored
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] rd_word_in;
    logic [ADDR_WIDTH-1:0] wr_word_in;
    logic                  unused_addr_bits;

    assign rd_word_in = cm_ReadAddr[ADDR_WIDTH+1:2];
    assign wr_word_in = cm_WriteAddr[ADDR_WIDTH+1:2];

    assign unused_addr_bits = ^{cm_ReadAddr[31:ADDR_WIDTH+2],  cm_ReadAddr[1:0],
                                cm_WriteAddr[31:ADDR_WIDTH+2], cm_WriteAddr[1:0]};

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [31:0]           mem       [MEM_WORDS];
    logic [ADDR_WIDTH-1:0] wbuf_addr [WBUF_DEPTH];
    logic [31:0]           wbuf_data [WBUF_DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      wbuf_count;

    logic                  wbuf_empty;
    logic                  wbuf_full;
    logic                  drain;
    logic                  enq;
    logic                  drop;

    // ------------------------------------------------------------------------
    // Read-side state
    // ------------------------------------------------------------------------
    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [3:0]            lat_cnt;
    logic [3:0]            next_lat_cnt;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic                  capture_addr;
    logic                  fire;

    logic                  raw_hit;
    logic [PTR_W-1:0]      scan_idx;
    logic [31:0]           ram_rdata;
    logic [31:0]           resp_data;
`ifdef MEM_RAW_BYPASS_EN
    logic [31:0]           fwd_data;
`endif

    // ------------------------------------------------------------------------
    // Posted-write buffer control
    // ------------------------------------------------------------------------
    // The head entry retires every cycle the buffer holds anything, in every
    // FSM state. On a full buffer an incoming write still fits when the head
    // retires in the same cycle. It is dropped only when nothing drains.
    assign wbuf_empty = (wbuf_count == '0);
    assign wbuf_full  = (wbuf_count == WBUF_FULL_CNT);
    assign drain      = !wbuf_empty;
    assign enq        = cm_WriteValid && (!wbuf_full || drain);
    assign drop       = cm_WriteValid && wbuf_full && !drain;

    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples pre-edge values; blocking assignments here would make
    // the result depend on block evaluation order.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wbuf_count    <= '0;
            wbuf_Overflow <= 1'b0;
        end else begin
            if (enq)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (drain) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, drain})
                2'b10:   wbuf_count <= wbuf_count + CNT_W'(1);
                2'b01:   wbuf_count <= wbuf_count - CNT_W'(1);
                default: wbuf_count <= wbuf_count;
            endcase
            if (drop) wbuf_Overflow <= 1'b1;
        end
    end

    // NOTE: storage arrays (buffer payload and RAM) have no reset. Emptying
    // the buffer only needs the pointers and count cleared, and the RAM must
    // keep its contents across Reset. Leaving them unreset also lets them map
    // onto RAM primitives.
    always_ff @(posedge CLK) begin
        if (enq) begin
            wbuf_addr[wr_ptr] <= wr_word_in;
            wbuf_data[wr_ptr] <= cm_WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (drain) begin
            mem[wbuf_addr[rd_ptr]] <= wbuf_data[rd_ptr];
        end
    end

    // ------------------------------------------------------------------------
    // RAW detection against the latched read address
    // ------------------------------------------------------------------------
    // The scan runs oldest to newest, so the last hit is the newest write to
    // the word. That is the value the RAM will hold once the buffer drains.
    // NOTE: every variable driven here gets a default before the loop.
    // Otherwise a path that leaves it unassigned would infer a latch.
    always_comb begin
        raw_hit  = 1'b0;
        scan_idx = '0;
`ifdef MEM_RAW_BYPASS_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            scan_idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < wbuf_count) && (wbuf_addr[scan_idx] == rd_word)) begin
                raw_hit  = 1'b1;
`ifdef MEM_RAW_BYPASS_EN
                fwd_data = wbuf_data[scan_idx];
`endif
            end
        end
    end

    // The RAM read is asynchronous. Its value is sampled into cm_ReadData on
    // the same edge that raises cm_ReadReady. The head entry writing the RAM
    // on that edge is still visible to the scan above.
    assign ram_rdata = mem[rd_word];

`ifdef MEM_RAW_BYPASS_EN
    assign resp_data = raw_hit ? fwd_data : ram_rdata;
`else
    assign resp_data = ram_rdata;
`endif

    // ------------------------------------------------------------------------
    // Read FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        next_state   = state;
        next_lat_cnt = lat_cnt;
        capture_addr = 1'b0;
        fire         = 1'b0;
        case (state)
            ST_IDLE: begin
                // Requests arriving in any other state are dropped silently.
                if (cm_ReadValid) begin
                    capture_addr = 1'b1;
                    next_lat_cnt = LAT_LOAD;
                    next_state   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == 4'd0) begin
`ifdef MEM_RAW_BYPASS_EN
                    next_state = ST_RESP;
                    fire       = 1'b1;
`else
                    if (raw_hit) begin
                        next_state = ST_STALL;
                    end else begin
                        next_state = ST_RESP;
                        fire       = 1'b1;
                    end
`endif
                end else begin
                    next_lat_cnt = lat_cnt - 4'd1;
                end
            end
            ST_STALL: begin
                // Wait until no buffered write targets the word. The RAM
                // then holds the newest value.
                if (!raw_hit) begin
                    next_state = ST_RESP;
                    fire       = 1'b1;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read FSM: registers and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            lat_cnt      <= 4'd0;
            rd_word      <= '0;
            cm_ReadReady <= 1'b0;
            cm_ReadData  <= 32'd0;
            mem_Busy     <= 1'b0;
        end else begin
            state        <= next_state;
            lat_cnt      <= next_lat_cnt;
            if (capture_addr) rd_word <= rd_word_in;
            cm_ReadReady <= fire;
            if (fire) cm_ReadData <= resp_data;
            mem_Busy     <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// ============================================================================
// tb_main_mem_responder
// ----------------------------------------------------------------------------
// Self-checking bench for main_mem_responder. A behavioural model keeps a
// plain word array of the memory contents and the age of the one outstanding
// read. Every cycle it compares the DUT outputs against what that model
// allows.
// ============================================================================
module tb_main_mem_responder;

    localparam int AW           = 10;
    localparam int LAT          = 4;
    localparam int DEPTH        = 2;
    localparam int STALL_BUDGET = 30;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        cm_ReadValid = 1'b0;
    logic [31:0] cm_ReadAddr = '0;
    logic        cm_WriteValid = 1'b0;
    logic [31:0] cm_WriteAddr = '0;
    logic [31:0] cm_WriteData = '0;
    logic        cm_ReadReady;
    logic [31:0] cm_ReadData;
    logic        mem_Busy;
    logic        wbuf_Overflow;

    main_mem_responder #(
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (LAT),
        .WBUF_DEPTH   (DEPTH)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .cm_ReadValid  (cm_ReadValid),
        .cm_ReadAddr   (cm_ReadAddr),
        .cm_WriteValid (cm_WriteValid),
        .cm_WriteAddr  (cm_WriteAddr),
        .cm_WriteData  (cm_WriteData),
        .cm_ReadReady  (cm_ReadReady),
        .cm_ReadData   (cm_ReadData),
        .mem_Busy      (mem_Busy),
        .wbuf_Overflow (wbuf_Overflow)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int              n_vec = 0;
    int              n_err = 0;
    logic [31:0]     model_mem [1 << AW];
    bit              pend = 1'b0;       // a read is outstanding
    bit              resp_flag = 1'b0;  // a response was seen this cycle
    bit              touched = 1'b0;    // its word was written after acceptance
    int              pend_age = 0;
    logic [AW-1:0]   pend_word = '0;
    logic [31:0]     exp_last = '0;
    int              resp_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    // Byte address for a word with random junk in the ignored bits.
    function automatic logic [31:0] addr_of(input int word);
        return ($urandom & 32'hFFFF_F003) | (32'(word) << 2);
    endfunction

    // One clock cycle: drive inputs, let the edge happen, then check outputs.
    task automatic cyc(input bit rv, input logic [31:0] ra,
                       input bit wv, input logic [31:0] wa, input logic [31:0] wd);
        bit accept;
        bit exact;
        cm_ReadValid  = rv;
        cm_ReadAddr   = ra;
        cm_WriteValid = wv;
        cm_WriteAddr  = wa;
        cm_WriteData  = wd;
        accept = rv && !pend && !resp_flag;
        @(posedge CLK);
        #1;
        resp_flag = 1'b0;
        if (pend) pend_age++;
`ifdef MEM_RAW_BYPASS_EN
        exact = 1'b1;
`else
        exact = !touched;
`endif
        if (cm_ReadReady) begin
            if (!pend) begin
                check("ready_spurious", 32'(cm_ReadReady), 32'd0);
            end else begin
                // Data reflects all writes up to the previous edge.
                check("rdata", cm_ReadData, model_mem[pend_word]);
                if (exact) check("latency", 32'(pend_age), 32'(LAT));
                else       check("latency_min", 32'(pend_age >= LAT), 32'd1);
                exp_last = model_mem[pend_word];
                pend      = 1'b0;
                resp_flag = 1'b1;
                resp_count++;
            end
        end else begin
            check("rdata_hold", cm_ReadData, exp_last);
            if (pend && exact && pend_age == LAT)
                check("ready_at_latency", 32'(cm_ReadReady), 32'd1);
            if (pend && pend_age > LAT + STALL_BUDGET) begin
                check("ready_timeout", 32'(cm_ReadReady), 32'd1);
                pend = 1'b0;
            end
        end
        if (wv) begin
            if (pend && word_of(wa) == pend_word) touched = 1'b1;
            model_mem[word_of(wa)] = wd;
        end
        if (accept) begin
            pend      = 1'b1;
            pend_word = word_of(ra);
            pend_age  = 0;
            touched   = 1'b0;
        end
        check("busy", 32'(mem_Busy), 32'(pend || resp_flag));
        check("overflow", 32'(wbuf_Overflow), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic model_reset();
        pend      = 1'b0;
        resp_flag = 1'b0;
        touched   = 1'b0;
        exp_last  = 32'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic [31:0] d;

        // ---------------- reset state ----------------
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", 32'(cm_ReadReady), 32'd0);
        check("rst_data", cm_ReadData, 32'd0);
        check("rst_busy", 32'(mem_Busy), 32'd0);
        check("rst_ovf", 32'(wbuf_Overflow), 32'd0);
        Reset = 1'b0;
        model_reset();
        idle(2);

        // ---------------- preload every RAM word through the write port ----------------
        for (int w = 0; w < (1 << AW); w++) begin
            d = (w == 4) ? 32'hDEAD_BEEF : $urandom;
            cyc(1'b0, 32'd0, 1'b1, addr_of(w), d);
        end
        idle(3);

        // ---------------- plain read of word 4 ----------------
        r0 = resp_count;
        cyc(1'b1, 32'h0000_0010, 1'b0, 32'd0, 32'd0);
        idle(LAT + 2);
        check("t1_resp_count", 32'(resp_count - r0), 32'd1);
        check("t1_data_held", cm_ReadData, 32'hDEAD_BEEF);

        // ---------------- write then read next cycle ----------------
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_0020, 32'h1234_5678);
        cyc(1'b1, 32'h0000_0020, 1'b0, 32'd0, 32'd0);
        idle(LAT + 3);
        check("t2_data", cm_ReadData, 32'h1234_5678);

        // Same-cycle write/read, then more writes to the word while waiting
        cyc(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0020, 32'hAAAA_0001);
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_0020, 32'hAAAA_0002);
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_0020, 32'hAAAA_0003);
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_0020, 32'hAAAA_0004);
        idle(LAT + 6);
        check("t2_raw_data", cm_ReadData, 32'hAAAA_0004);

        // ---------------- three writes to one word, newest wins ----------------
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_0040, 32'h1);
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_0040, 32'h2);
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_0040, 32'h3);
        cyc(1'b1, 32'h0000_0040, 1'b0, 32'd0, 32'd0);
        idle(LAT + 4);
        check("t3_newest", cm_ReadData, 32'h3);
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_0010, 32'h0BAD_F00D);
        cyc(1'b1, 32'h0000_0040, 1'b0, 32'd0, 32'd0);
        idle(LAT + 4);
        check("t3_ram_word16", cm_ReadData, 32'h3);

        // ---------------- sustained write burst on a 2-entry buffer ----------------
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b1, addr_of(300 + i), $urandom);
        check("t4_no_overflow", 32'(wbuf_Overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, addr_of(300 + i), 1'b0, 32'd0, 32'd0);
            idle(LAT + 2);
            check("t4_burst_word", cm_ReadData, model_mem[300 + i]);
        end

        // ---------------- second request while busy is ignored ----------------
        r0 = resp_count;
        cyc(1'b1, addr_of(100), 1'b0, 32'd0, 32'd0);
        idle(1);
        cyc(1'b1, addr_of(200), 1'b0, 32'd0, 32'd0);
        idle(LAT + 6);
        check("t5_one_resp", 32'(resp_count - r0), 32'd1);
        check("t5_first_addr", cm_ReadData, model_mem[100]);

        // ---------------- reset during an outstanding read ----------------
        idle(2);
        r0 = resp_count;
        cyc(1'b1, addr_of(5), 1'b0, 32'd0, 32'd0);
        idle(2);
        Reset = 1'b1;
        #2;
        check("t6_rst_ready", 32'(cm_ReadReady), 32'd0);
        check("t6_rst_data", cm_ReadData, 32'd0);
        check("t6_rst_busy", 32'(mem_Busy), 32'd0);
        check("t6_rst_ovf", 32'(wbuf_Overflow), 32'd0);
        @(posedge CLK);
        #1;
        check("t6_rst_ready_hold", 32'(cm_ReadReady), 32'd0);
        Reset = 1'b0;
        model_reset();
        idle(LAT + 3);
        check("t6_aborted", 32'(resp_count - r0), 32'd0);
        cyc(1'b1, addr_of(5), 1'b0, 32'd0, 32'd0);
        idle(LAT + 2);
        check("t6_fresh_resp", 32'(resp_count - r0), 32'd1);
        check("t6_fresh_data", cm_ReadData, model_mem[5]);

        // ---------------- random mix over a few words to provoke hazards ----------------
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 2) == 0, addr_of($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, addr_of($urandom_range(0, 7)), $urandom);
        end
        idle(LAT + STALL_BUDGET + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Main-memory side of the cache-to-memory (cm_) interface; answers cache line-fill reads and absorbs write-backs.
- Word-organised backing RAM with a programmable read latency.
- A small posted-write buffer lets fire-and-forget cm_WriteValid pulses be accepted every cycle.
- Sits between the 4-way cache and the simulation/FPGA memory array.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words; word index = cm_*Addr[ADDR_WIDTH+1:2].
READ_LATENCY, 4, cycles from accepted read request to cm_ReadReady; legal range 1..15.
WBUF_DEPTH, 4, posted-write buffer entries; power of two, at least 2.

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
cm_ReadValid  in  1  one-cycle read request pulse
cm_ReadAddr  in  32  byte address of read
cm_WriteValid  in  1  one-cycle write pulse; no ready, must be accepted or flagged
cm_WriteAddr  in  32  byte address of write
cm_WriteData  in  32  write data
cm_ReadReady  out  1  one-cycle pulse; cm_ReadData valid in same cycle
cm_ReadData  out  32  read data; holds last returned value between responses
mem_Busy  out  1  high while a read is outstanding (state != IDLE)
wbuf_Overflow  out  1  sticky; set when a write is dropped on a full buffer

Behaviour:
- Reset values (asynchronous): cm_ReadReady=0, cm_ReadData=0, mem_Busy=0, wbuf_Overflow=0.
  - State goes to IDLE; write buffer emptied.
  - RAM contents are not cleared.
  - A read in flight is aborted; no cm_ReadReady is issued for it.
- Address bits [1:0] and bits above ADDR_WIDTH+1 are ignored.
- State machine:
  - IDLE: cm_ReadValid=1 latches the word address, loads latency counter with READ_LATENCY-1, goes to WAIT.
  - WAIT: counter decrements each cycle. At 0, if no RAW hazard, go to RESP; otherwise go to STALL.
  - STALL (only without MEM_RAW_BYPASS_EN): stay while any buffered entry matches the latched address; go to RESP the cycle none matches.
  - RESP: cm_ReadReady=1 for exactly one cycle with cm_ReadData; return to IDLE.
- Outputs are registered. Without a hazard, cm_ReadReady rises in cycle T+READ_LATENCY for a request sampled in cycle T.
- cm_ReadValid while not IDLE is ignored: no queuing, no flag.
- Returned data reflects every write accepted in cycles up to and including the cycle before cm_ReadReady.
- Write buffer (FIFO):
  - Every cm_WriteValid cycle enqueues {word address, data}.
  - One entry drains to RAM per cycle whenever the buffer is non-empty; drain runs in every state.
  - Enqueue and drain in the same cycle are both performed. When full, an incoming write is accepted only if a drain happens that cycle.
  - Write on full with no drain possible: write dropped, wbuf_Overflow set until Reset.
  - Pointers wrap modulo WBUF_DEPTH. The count needs log2(WBUF_DEPTH)+1 bits to tell full from empty.
- Same-cycle write and read request to the same address: the write is ordered first.
- Multiple buffered writes to one address drain in arrival order; RAM ends with the newest.

Optional Feature:
- Macro: MEM_RAW_BYPASS_EN
- Defined: on a RAW hazard, the response takes the data of the newest matching buffer entry (forwarding). STALL is unreachable; latency is always exactly READ_LATENCY.
- Undefined: no forwarding comparator on the data path. A hazard sends the FSM to STALL until matching entries drain. Latency is READ_LATENCY + stall cycles, and mem_Busy stays high throughout.

Test Plan:
- Reset, then read 0x0000_0010 (word 4, preloaded 0xDEAD_BEEF) in cycle T -> cm_ReadReady one cycle at T+4, cm_ReadData=0xDEAD_BEEF, held after the pulse.
- Write 0x0000_0020=0x1234_5678, then read 0x20 on the next cycle -> 0x1234_5678. With the macro, returned at T+4; without it, at T+4 or later with mem_Busy high until then.
- Writes to 0x40 with 0x1, 0x2, 0x3 on consecutive cycles, then read 0x40 -> returns 0x3; RAM word 16 = 0x3 after drain.
- WBUF_DEPTH=2, sustained one-write-per-cycle burst of 8 -> no overflow because drain keeps pace; wbuf_Overflow stays 0 and all 8 words land in RAM.
- Second cm_ReadValid pulse 2 cycles into an outstanding read -> ignored; exactly one cm_ReadReady pulse, for the first address.
- Reset asserted at T+2 of an outstanding read -> no cm_ReadReady; all outputs 0. A fresh read after release returns correct data at +READ_LATENCY.
